// File: rtl/traffic_pkg.sv
// Shared encodings for the multi-approach intersection controller:
// phase codes, lamp codes and the IDLE flash half-period.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    ALLRED = 3'd3,
    WALK   = 3'd4
  } state_t;

  localparam logic [1:0] LAMP_OFF    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_RED    = 2'b11;

  localparam int FLASH_T = 4;

endpackage

// File: rtl/traffic_timer.sv
// Loadable CNT_W-bit phase down-counter; load wins over dec, zero flags count==0.
module traffic_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!rst)      r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (dec)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign count = r_cnt;
  assign zero  = (r_cnt == '0);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach intersection controller: GREEN/YELLOW/ALLRED rotation with an
// end-of-rotation WALK phase. Optional IDLE yellow flash under TRAFFIC_FLASH_EN.
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int NUM_DIR  = 2,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 5,
  localparam int DIR_W   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ped_req,
  output logic [2:0]           state,
  output logic [DIR_W-1:0]     active_dir,
  output logic [2*NUM_DIR-1:0] light,
  output logic                 walk,
  output logic                 ped_ack,
  output logic [CNT_W-1:0]     timer
);

  localparam logic [CNT_W-1:0] G_LD   = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LD   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] A_LD   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] W_LD   = CNT_W'(WALK_T - 1);
  localparam logic [DIR_W-1:0] LAST_D = DIR_W'(NUM_DIR - 1);

  state_t           r_state, w_nxt;
  logic [DIR_W-1:0] r_dir, w_nxt_dir;
  logic             r_pend, r_ack;
  logic             w_load, w_dec, w_zero, w_walk_entry;
  logic [CNT_W-1:0] w_ld_val, w_count;
  logic [2*NUM_DIR-1:0] w_light;

  traffic_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_ld_val),
    .dec      (w_dec),
    .count    (w_count),
    .zero     (w_zero)
  );

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_state <= IDLE;
      r_dir   <= '0;
    end else begin
      r_state <= w_nxt;
      r_dir   <= w_nxt_dir;
    end
  end

  // Each phase reloads the timer on entry and exits on the cycle it reads zero.
  always_comb begin
    w_nxt     = r_state;
    w_nxt_dir = r_dir;
    w_load    = 1'b0;
    w_ld_val  = '0;
    w_dec     = 1'b0;
    if (!en) begin
      w_nxt     = IDLE;
      w_nxt_dir = '0;
      w_load    = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt     = GREEN;
          w_nxt_dir = '0;
          w_load    = 1'b1;
          w_ld_val  = G_LD;
        end
        GREEN: begin
          if (w_zero) begin
            w_nxt    = YELLOW;
            w_load   = 1'b1;
            w_ld_val = Y_LD;
          end else w_dec = 1'b1;
        end
        YELLOW: begin
          if (w_zero) begin
            w_nxt    = ALLRED;
            w_load   = 1'b1;
            w_ld_val = A_LD;
          end else w_dec = 1'b1;
        end
        ALLRED: begin
          if (w_zero) begin
            w_load = 1'b1;
            if (r_dir != LAST_D) begin
              w_nxt     = GREEN;
              w_nxt_dir = r_dir + DIR_W'(1);
              w_ld_val  = G_LD;
            end else if (r_pend || ped_req) begin
              w_nxt    = WALK;
              w_ld_val = W_LD;
            end else begin
              w_nxt     = GREEN;
              w_nxt_dir = '0;
              w_ld_val  = G_LD;
            end
          end else w_dec = 1'b1;
        end
        WALK: begin
          if (w_zero) begin
            w_nxt     = GREEN;
            w_nxt_dir = '0;
            w_load    = 1'b1;
            w_ld_val  = G_LD;
          end else w_dec = 1'b1;
        end
        default: begin
          w_nxt     = IDLE;
          w_nxt_dir = '0;
          w_load    = 1'b1;
        end
      endcase
    end
  end

  assign w_walk_entry = (w_nxt == WALK) && (r_state != WALK);

  // Entering WALK consumes the request, even one arriving in that same cycle.
  always_ff @(posedge clock) begin
    if (!rst || !en) begin
      r_pend <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_walk_entry;
      if (w_walk_entry)                  r_pend <= 1'b0;
      else if (ped_req && r_state != WALK) r_pend <= 1'b1;
    end
  end

`ifdef TRAFFIC_FLASH_EN
  localparam int FL_W = $clog2(2 * FLASH_T);
  logic [FL_W-1:0] r_flash;

  always_ff @(posedge clock) begin
    if (!rst || (w_nxt == IDLE && r_state != IDLE)) r_flash <= '0;
    else if (r_flash == FL_W'(2 * FLASH_T - 1))     r_flash <= '0;
    else                                            r_flash <= r_flash + FL_W'(1);
  end
`endif

  always_comb begin
    w_light = '0;
    for (int k = 0; k < NUM_DIR; k++) begin
      case (r_state)
`ifdef TRAFFIC_FLASH_EN
        IDLE:   w_light[2*k +: 2] = (r_flash < FL_W'(FLASH_T)) ? LAMP_YELLOW : LAMP_OFF;
`endif
        GREEN:  w_light[2*k +: 2] = (r_dir == DIR_W'(k)) ? LAMP_GREEN : LAMP_RED;
        YELLOW: w_light[2*k +: 2] = (r_dir == DIR_W'(k)) ? LAMP_YELLOW : LAMP_RED;
        ALLRED, WALK: w_light[2*k +: 2] = LAMP_RED;
        default: w_light[2*k +: 2] = LAMP_OFF;
      endcase
    end
  end

  assign state      = r_state;
  assign active_dir = r_dir;
  assign light      = w_light;
  assign walk       = (r_state == WALK);
  assign ped_ack    = r_ack;
  assign timer      = w_count;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Scoreboard bench: a behavioural phase model predicts every output each cycle,
// plus window checks on WALK length and ped_ack pulse count.
module tb_traffic_ctrl_multi;

  localparam int NUM_DIR = 2, CNT_W = 8;
  localparam int GT = 8, YT = 3, AT = 2, WT = 5;
  localparam int DIR_W = 1;

  logic                 clock, rst, en, ped_req;
  logic [2:0]           state;
  logic [DIR_W-1:0]     active_dir;
  logic [2*NUM_DIR-1:0] light;
  logic                 walk, ped_ack;
  logic [CNT_W-1:0]     timer;

  traffic_ctrl_multi #(
    .NUM_DIR(NUM_DIR), .CNT_W(CNT_W), .GREEN_T(GT),
    .YELLOW_T(YT), .ALLRED_T(AT), .WALK_T(WT)
  ) dut (
    .clock(clock), .rst(rst), .en(en), .ped_req(ped_req),
    .state(state), .active_dir(active_dir), .light(light),
    .walk(walk), .ped_ack(ped_ack), .timer(timer)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int st; int dir; int lt; int wk; int ack; int tm;
  } exp_t;
  exp_t q[$];

  int n_vec = 0, n_err = 0;
  int walk_cnt = 0, ack_cnt = 0;

  // Model state: elapsed-cycle counter per phase rather than a countdown.
  int m_state = 0, m_dir = 0, m_el = 0, m_flash = 0;
  bit m_pend = 0, m_ack = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur(input int s);
    case (s)
      1: return GT;
      2: return YT;
      3: return AT;
      4: return WT;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit e, input bit p);
    int ns, nd, nel;
    bit entry;
    ns = 0; nd = 0; nel = 0; entry = 0;
    if (!r) begin
      m_state = 0; m_dir = 0; m_el = 0; m_pend = 0; m_ack = 0; m_flash = 0;
      return;
    end
    if (e) begin
      nd = m_dir;
      if (m_state == 0) begin
        ns = 1; nd = 0;
      end else if (m_el < dur(m_state) - 1) begin
        ns = m_state; nel = m_el + 1;
      end else begin
        case (m_state)
          1: ns = 2;
          2: ns = 3;
          3: if (m_dir < NUM_DIR - 1) begin ns = 1; nd = m_dir + 1; end
             else if (m_pend || p) ns = 4;
             else begin ns = 1; nd = 0; end
          default: begin ns = 1; nd = 0; end
        endcase
      end
      entry = (ns == 4) && (m_state != 4);
      if (entry) m_pend = 0;
      else if (p && m_state != 4) m_pend = 1;
    end else m_pend = 0;
    m_ack = entry;
    m_flash = (ns == 0 && m_state != 0) ? 0 : (m_flash + 1) % 8;
    m_state = ns; m_dir = nd; m_el = nel;
  endtask

  function automatic int exp_light();
    int lt;
    lt = 0;
    for (int k = 0; k < NUM_DIR; k++) begin
      int c;
      c = 0;
      case (m_state)
`ifdef TRAFFIC_FLASH_EN
        0: c = (m_flash < 4) ? 2 : 0;
`endif
        1: c = (k == m_dir) ? 1 : 3;
        2: c = (k == m_dir) ? 2 : 3;
        3, 4: c = 3;
        default: c = 0;
      endcase
      lt = lt | (c << (2 * k));
    end
    return lt;
  endfunction

  task automatic tick();
    exp_t e, x;
    model_step(rst, en, ped_req);
    e.st = m_state; e.dir = m_dir; e.lt = exp_light();
    e.wk = (m_state == 4); e.ack = m_ack;
    e.tm = (m_state == 0) ? 0 : dur(m_state) - 1 - m_el;
    q.push_back(e);
    @(posedge clock);
    #1;
    x = q.pop_front();
    chk("state", 32'(state), x.st);
    chk("active_dir", 32'(active_dir), x.dir);
    chk("light", 32'(light), x.lt);
    chk("walk", 32'(walk), x.wk);
    chk("ped_ack", 32'(ped_ack), x.ack);
    chk("timer", 32'(timer), x.tm);
    if (walk === 1'b1) walk_cnt++;
    if (ped_ack === 1'b1) ack_cnt++;
  endtask

  task automatic wait_for(input int s, input int d);
    int budget;
    budget = 100;
    while (!(m_state == s && m_dir == d) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) chk("wait_timeout", 32'(m_state), 32'(s));
  endtask

  task automatic ped_pulse();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; ped_req = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'(state), 0);
    chk("reset_light", 32'(light), 0);
    rst = 1'b1;
    tick();
    chk("first_green_timer", 32'(timer), GT - 1);
    chk("first_green_light", 32'(light), 32'h0D);

    // Plain rotation; dir0 GREEN returns 26 cycles later.
    repeat (26) tick();
    chk("rotation_period", 32'(state), 1);
    chk("rotation_dir", 32'(active_dir), 0);
    chk("rotation_timer", 32'(timer), GT - 1);

    // Pedestrian request served once, next rotation has no WALK.
    walk_cnt = 0; ack_cnt = 0;
    ped_pulse();
    repeat (40) tick();
    chk("walk_len", 32'(walk_cnt), WT);
    chk("ack_pulses", 32'(ack_cnt), 1);
    walk_cnt = 0;
    repeat (26) tick();
    chk("no_second_walk", 32'(walk_cnt), 0);

    // Enable drop mid-YELLOW of dir1 discards the pending request.
    wait_for(1, 0);
    ped_pulse();
    wait_for(2, 1);
    tick();
    en = 1'b0;
    tick();
    chk("en_drop_idle", 32'(state), 0);
    en = 1'b1;
    walk_cnt = 0;
    repeat (40) tick();
    chk("no_walk_after_drop", 32'(walk_cnt), 0);

    // Reset during WALK wins over enable.
    wait_for(1, 0);
    ped_pulse();
    wait_for(4, NUM_DIR - 1);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_walk_state", 32'(state), 0);
    chk("rst_in_walk_ack", 32'(ped_ack), 0);
    rst = 1'b1;
    repeat (20) tick();

    // Held enable low exercises IDLE lighting.
    en = 1'b0;
    repeat (12) tick();
    en = 1'b1;

    // Random pedestrian traffic with occasional enable drops.
    for (int i = 0; i < 200; i++) begin
      ped_req = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
Parametrised multi-direction intersection controller, the next generation of the single-approach traffic FSM.
- Rotates right-of-way across NUM_DIR approaches using GREEN -> YELLOW -> ALLRED phases, each timed by an internal down-counter.
- Latches pedestrian requests and serves them with a WALK phase at the end of each full rotation.
- Sits between the board-level enable/button inputs and the per-lane LED drivers.

Parameters:
NUM_DIR, 2, number of approaches (2..4)
CNT_W, 8, phase timer width in bits
GREEN_T, 8, GREEN duration in cycles (1..2^CNT_W)
YELLOW_T, 3, YELLOW duration in cycles (1..2^CNT_W)
ALLRED_T, 2, ALLRED duration in cycles (1..2^CNT_W)
WALK_T, 5, WALK duration in cycles (1..2^CNT_W)

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
en  in  1  run enable; low forces IDLE
ped_req  in  1  pedestrian request, level, sampled each clock
state  out  3  current phase (package encoding)
active_dir  out  DIR_W  approach holding right-of-way; DIR_W = max(1, clog2(NUM_DIR))
light  out  2*NUM_DIR  per-approach lamp code; approach k occupies bits [2k+1:2k]
walk  out  1  pedestrian walk lamp
ped_ack  out  1  one-cycle pulse on WALK entry
timer  out  CNT_W  remaining cycles in current phase, minus one

Behaviour:
- Priority per clock: rst low > en low > FSM step.
- Reset values: state=IDLE, active_dir=0, light all 00, walk=0, ped_ack=0, timer=0, ped_pend=0.
- Lamp codes: 00 off, 01 green, 10 yellow, 11 red.
- State encoding: IDLE=0, GREEN=1, YELLOW=2, ALLRED=3, WALK=4.
- en low in any state: next state=IDLE, active_dir=0, ped_pend cleared, timer=0.
- IDLE with en high: next clock enters GREEN with active_dir=0.
- Timer rule:
  - Entering a phase of duration D loads timer=D-1.
  - timer decrements each clock.
  - The phase exits on the clock where timer==0, so every phase lasts exactly D cycles.
  - D=1 gives a single-cycle phase.
- Transitions:
  - GREEN -> YELLOW.
  - YELLOW -> ALLRED.
  - ALLRED with active_dir<NUM_DIR-1 -> GREEN with active_dir+1.
  - ALLRED with active_dir==NUM_DIR-1: to WALK if (ped_pend|ped_req), else GREEN with active_dir=0 (wrap).
  - WALK -> GREEN with active_dir=0.
- Lights by state:
  - IDLE: all 00.
  - GREEN/YELLOW: active approach 01/10, all others 11.
  - ALLRED and WALK: all 11.
- walk=1 only in WALK.
- Pedestrian handling:
  - ped_pend sets on any cycle with ped_req=1 outside WALK.
  - ped_pend clears on WALK entry.
  - ped_req during WALK is ignored.
  - ped_ack=1 on the first WALK cycle only.
- Rotation period without pedestrians: NUM_DIR*(GREEN_T+YELLOW_T+ALLRED_T) cycles; a served WALK adds WALK_T.
- Unused state codes (5..7) recover to IDLE on the next clock.

Optional Feature:
Macro TRAFFIC_FLASH_EN.
- Defined: IDLE drives all approaches to 10 (yellow) for FLASH_T=4 cycles, then 00 for 4 cycles, repeating, via a free-running flash counter.
  - The flash counter resets to 0 on rst low and on IDLE entry.
- Undefined: IDLE lights stay 00 and no flash counter is built.

Decomposition:
- Package traffic_pkg holds:
  - state encoding constants IDLE/GREEN/YELLOW/ALLRED/WALK (3-bit);
  - lamp codes LAMP_OFF/LAMP_GREEN/LAMP_YELLOW/LAMP_RED (2-bit);
  - FLASH_T.
- One sub-module, traffic_timer: CNT_W-bit loadable down-counter.
  - Inputs: load, load_val, dec.
  - Output: zero flag.
  - Instantiated once.

Test Plan:
- Reset and start: rst low 3 clocks, then rst=1 with en=1 -> state=IDLE and light=0000 on the first high cycle; GREEN dir0 (light=1101) next clock, timer=7.
- Full rotation with NUM_DIR=2 and no ped_req:
  - dir0 GREEN 8 cycles, YELLOW 3 (light=1110), ALLRED 2 (1111);
  - dir1 GREEN starts 13 cycles after dir0 GREEN start (light=0111);
  - dir0 GREEN returns at cycle 26.
- Pedestrian request: single-cycle ped_req pulse during dir0 GREEN -> WALK follows dir1 ALLRED with walk=1 for 5 cycles; ped_ack high exactly 1 cycle; next rotation has no WALK.
- Enable drop: en=0 mid-YELLOW of dir1 with ped_pend=1 -> IDLE next clock, active_dir=0, lights 0000; en=1 resumes at dir0 GREEN; no WALK at the end of that rotation.
- Reset priority: rst=0 and en=1 during WALK -> all outputs at reset values next clock; ped_ack stays 0.
- TRAFFIC_FLASH_EN defined, en=0 -> light alternates 1010 for 4 cycles and 0000 for 4 cycles.
